// File: rtl/key_led_n_if.sv
// key_led_n_if: key pins in, LED drive / press pulses / mode out.
// slave is the controller side, master is the board / driver side.
interface key_led_n_if #(
    parameter int KEY_NUM = 2
);
    logic [KEY_NUM-1:0]   key;
    logic [KEY_NUM-1:0]   led;
    logic [KEY_NUM-1:0]   key_press;
    logic [2*KEY_NUM-1:0] mode;

    modport master (
        output key,
        input  led,
        input  key_press,
        input  mode
    );

    modport slave (
        input  key,
        output led,
        output key_press,
        output mode
    );
endinterface

// File: rtl/key_led_n.sv
// key_led_n: per-channel sync, debounce, press detect and an
// OFF -> ON -> BLINK mode cycle, with one shared blink phase.
module key_led_n #(
    parameter int KEY_NUM   = 2,
    parameter int DEB_CNT   = 1_000_000,
    parameter int BLINK_CNT = 25_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    key_led_n_if.slave  bus
);
    localparam int DW = $clog2(DEB_CNT + 1);
    localparam int BW = $clog2(BLINK_CNT);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CNT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

    typedef enum logic [1:0] {
        M_OFF   = 2'b00,
        M_ON    = 2'b01,
        M_BLINK = 2'b10
    } mode_e;

    logic [KEY_NUM-1:0] meta_q;
    logic [KEY_NUM-1:0] sync_q;
    logic [KEY_NUM-1:0] stable_q;
    logic [KEY_NUM-1:0] stable_d;
    logic [KEY_NUM-1:0] stable_dly_q;
    logic [KEY_NUM-1:0] press_d;
    logic [KEY_NUM-1:0] press_q;
    logic [KEY_NUM-1:0] led_q;
    logic [DW-1:0]      cnt_q [KEY_NUM];
    logic [DW-1:0]      cnt_d [KEY_NUM];
    mode_e              mode_q [KEY_NUM];
    logic [2*KEY_NUM-1:0] mode_flat;

    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;

    // Debounce: stable follows sync only after DEB_CNT differing samples.
    always_comb begin
        for (int i = 0; i < KEY_NUM; i++) begin
            cnt_d[i]    = cnt_q[i];
            stable_d[i] = stable_q[i];
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end
        end
        press_d = stable_dly_q & ~stable_q;
    end

    // Two-flop synchroniser, debounce state and one-clock-late copy.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q       <= '1;
            sync_q       <= '1;
            stable_q     <= '1;
            stable_dly_q <= '1;
            for (int i = 0; i < KEY_NUM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q       <= bus.key;
            sync_q       <= meta_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < KEY_NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Free-running blink timer; phase flips on every wrap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    // Mode FSM per channel with registered press pulse and LED drive.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            press_q <= '0;
            led_q   <= '0;
            for (int i = 0; i < KEY_NUM; i++) begin
                mode_q[i] <= M_OFF;
            end
        end else begin
            press_q <= press_d;
            for (int i = 0; i < KEY_NUM; i++) begin
                led_q[i] <= (mode_q[i] == M_ON) ||
                            ((mode_q[i] == M_BLINK) && blink_phase_q);
                if (press_d[i]) begin
                    case (mode_q[i])
                        M_OFF:   mode_q[i] <= M_ON;
                        M_ON:    mode_q[i] <= M_BLINK;
                        default: mode_q[i] <= M_OFF;
                    endcase
                end
            end
        end
    end

    // Pack per-channel modes into the flat output bus.
    always_comb begin
        mode_flat = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            mode_flat[2*i +: 2] = mode_q[i];
        end
    end

    assign bus.led       = led_q;
    assign bus.key_press = press_q;
    assign bus.mode      = mode_flat;

endmodule

// File: tb/tb_key_led_n.sv
// tb_key_led_n: scoreboard bench for key_led_n.
// Expected press events are queued at stimulus time, popped on key_press.
module tb_key_led_n;
    localparam int KN  = 2;
    localparam int DEB = 10;
    localparam int BLK = 8;
    localparam int LAT = DEB + 3;

    typedef struct {
        int         ch;
        int         edge_n;
        logic [1:0] mode;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb [$];
    logic [1:0] m_mode [KN];

    key_led_n_if #(.KEY_NUM(KN)) bus ();

    key_led_n #(
        .KEY_NUM  (KN),
        .DEB_CNT  (DEB),
        .BLINK_CNT(BLK)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pop one expected event for every observed press pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.key_press != '0) begin
            for (int c = 0; c < KN; c++) begin
                if (bus.key_press[c]) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL spurious_press ch=%0d edge=%0d got pulse, required none",
                                 c, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.ch != c || e.edge_n != cyc ||
                            bus.mode[2*c +: 2] !== e.mode) begin
                            n_fail++;
                            $display("FAIL press_event got ch=%0d edge=%0d mode=%b required ch=%0d edge=%0d mode=%b",
                                     c, cyc, bus.mode[2*c +: 2], e.ch, e.edge_n, e.mode);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_press(input int ch, input int at);
        logic [1:0] nx;
        nx = (m_mode[ch] == 2'b10) ? 2'b00 : m_mode[ch] + 2'b01;
        m_mode[ch] = nx;
        sb.push_back('{ch: ch, edge_n: at, mode: nx});
    endtask

    task automatic press_key(input int ch, input int low_clks);
        bus.key[ch] = 1'b0;
        expect_press(ch, cyc + LAT);
        tick(low_clks);
        bus.key[ch] = 1'b1;
        tick(DEB + 4);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.key = '1;
        sb.delete();
        for (int c = 0; c < KN; c++) m_mode[c] = 2'b00;
        #200;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (bus.led !== 2'b00 || bus.mode !== 4'b0000 ||
            bus.key_press !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs got led=%b mode=%b kp=%b required 00/0000/00",
                     bus.led, bus.mode, bus.key_press);
        end
        tick(7);
        n_tests++;
        if (dut.blink_phase_q !== 1'b0) begin
            n_fail++;
            $display("FAIL phase_edge7 got %b required 0", dut.blink_phase_q);
        end
        tick(1);
        n_tests++;
        if (dut.blink_phase_q !== 1'b1) begin
            n_fail++;
            $display("FAIL phase_edge8 got %b required 1", dut.blink_phase_q);
        end
    endtask

    task automatic test_press();
        bus.key[0] = 1'b0;
        expect_press(0, cyc + LAT);
        tick(LAT);
        n_tests++;
        if (bus.led !== 2'b00) begin
            n_fail++;
            $display("FAIL led_before got %b required 00", bus.led);
        end
        tick(1);
        n_tests++;
        if (bus.led !== 2'b01) begin
            n_fail++;
            $display("FAIL led_after got %b required 01", bus.led);
        end
        tick(50 - LAT - 1);
        bus.key[0] = 1'b1;
        tick(DEB + 5);
        n_tests++;
        if (sb.size() != 0 || bus.mode !== 4'b0001) begin
            n_fail++;
            $display("FAIL press_done got pending=%0d mode=%b required 0/0001",
                     sb.size(), bus.mode);
        end
    endtask

    task automatic test_bounce();
        bus.key[0] = 1'b0; tick(5);
        bus.key[0] = 1'b1; tick(3);
        bus.key[0] = 1'b0; tick(6);
        bus.key[0] = 1'b1; tick(20);
        n_tests++;
        if (bus.mode !== 4'b0001) begin
            n_fail++;
            $display("FAIL bounce_mode got %b required 0001", bus.mode);
        end
        press_key(0, 20);
        n_tests++;
        if (sb.size() != 0 || bus.mode !== 4'b0010) begin
            n_fail++;
            $display("FAIL bounce_then_press got pending=%0d mode=%b required 0/0010",
                     sb.size(), bus.mode);
        end
    endtask

    task automatic test_blink();
        logic exp_led;
        do_reset();
        press_key(0, 20);
        n_tests++;
        if (bus.mode[1:0] !== 2'b01) begin
            n_fail++;
            $display("FAIL blink_seq1 got %b required 01", bus.mode[1:0]);
        end
        press_key(0, 20);
        n_tests++;
        if (bus.mode[1:0] !== 2'b10) begin
            n_fail++;
            $display("FAIL blink_seq2 got %b required 10", bus.mode[1:0]);
        end
        for (int k = 0; k < 24; k++) begin
            tick(1);
            exp_led = (((cyc - 1) / BLK) % 2) == 1;
            n_tests++;
            if (bus.led[0] !== exp_led || bus.led[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL blink_led edge=%0d got %b required %b",
                         cyc, bus.led, {1'b0, exp_led});
            end
        end
        press_key(0, 20);
        n_tests++;
        if (bus.mode[1:0] !== 2'b00 || bus.led !== 2'b00) begin
            n_fail++;
            $display("FAIL blink_seq3 got mode=%b led=%b required 00/00",
                     bus.mode[1:0], bus.led);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.key = 2'b00;
        expect_press(0, cyc + LAT);
        expect_press(1, cyc + LAT);
        tick(20);
        bus.key = 2'b11;
        tick(DEB + 4);
        n_tests++;
        if (sb.size() != 0 || bus.mode !== 4'b0101 || bus.led !== 2'b11) begin
            n_fail++;
            $display("FAIL simul got pending=%0d mode=%b led=%b required 0/0101/11",
                     sb.size(), bus.mode, bus.led);
        end
    endtask

    task automatic test_reset_mid();
        press_key(1, 20);
        n_tests++;
        if (bus.mode[3:2] !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_blink got %b required 10", bus.mode[3:2]);
        end
        bus.key[1] = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.led !== 2'b00 || bus.mode !== 4'b0000 ||
            bus.key_press !== 2'b00) begin
            n_fail++;
            $display("FAIL async_clear got led=%b mode=%b kp=%b required 00/0000/00",
                     bus.led, bus.mode, bus.key_press);
        end
        for (int c = 0; c < KN; c++) m_mode[c] = 2'b00;
        tick(3);
        n_tests++;
        if (bus.key_press !== 2'b00 || bus.mode !== 4'b0000) begin
            n_fail++;
            $display("FAIL in_reset got kp=%b mode=%b required 00/0000",
                     bus.key_press, bus.mode);
        end
        rst_n = 1'b1;
        expect_press(1, cyc + LAT);
        tick(20);
        bus.key[1] = 1'b1;
        tick(DEB + 4);
        n_tests++;
        if (sb.size() != 0 || bus.mode !== 4'b0100) begin
            n_fail++;
            $display("FAIL post_reset got pending=%0d mode=%b required 0/0100",
                     sb.size(), bus.mode);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.key = '1;
        test_reset();
        test_press();
        test_bounce();
        test_blink();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
